// File: rtl/piece_state_ctrl.sv
// Active-piece owner: commits candidate moves, runs spawn/lock/game-over sequence.
// Latency: accepted moves appear on cur_* one cycle after the event; all outputs registered.
// Backpressure: lock_req is held until lock_ack; non-PLAY mode freezes everything except the lock handshake.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mode                     game mode, block active only in MODE_PLAY
//   game_clk / btn_*_en      drop tick and button pulses (move events)
//   test_pos_x/y, test_rot   candidate position from the test-position stage
//   test_intersects          collision verdict for the candidate (same cycle)
//   next_piece, lock_ack     queued piece type, board-writer completion
//   cur_*                    committed position, rotation and piece type
//   lock_req, next_req       board write request (level), next-piece consume (pulse)
//   game_clk_rst, game_over  drop-timer restart (pulse), sticky spawn collision
//   piece_count              saturating count of locked pieces

`ifndef MODE_BITS
`define MODE_BITS 2
`endif
`ifndef MODE_PLAY
`define MODE_PLAY 2'd1
`endif
`ifndef BITS_X_POS
`define BITS_X_POS 4
`endif
`ifndef BITS_Y_POS
`define BITS_Y_POS 5
`endif
`ifndef BITS_ROT
`define BITS_ROT 2
`endif
`ifndef BITS_PER_BLOCK
`define BITS_PER_BLOCK 3
`endif
`ifndef EMPTY_BLOCK
`define EMPTY_BLOCK 3'd0
`endif
`ifndef BITS_SCORE
`define BITS_SCORE 14
`endif

module piece_state_ctrl #(
    parameter logic [`BITS_X_POS-1:0] SPAWN_X   = 4'd4,
    parameter logic [`BITS_Y_POS-1:0] SPAWN_Y   = 5'd0,
    parameter logic [`BITS_ROT-1:0]   SPAWN_ROT = 2'd0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [`MODE_BITS-1:0]      mode,
    input  logic                       game_clk,
    input  logic                       btn_left_en,
    input  logic                       btn_right_en,
    input  logic                       btn_rotate_en,
    input  logic [`BITS_X_POS-1:0]     test_pos_x,
    input  logic [`BITS_Y_POS-1:0]     test_pos_y,
    input  logic [`BITS_ROT-1:0]       test_rot,
    input  logic                       test_intersects,
    input  logic [`BITS_PER_BLOCK-1:0] next_piece,
    input  logic                       lock_ack,
    output logic [`BITS_X_POS-1:0]     cur_pos_x,
    output logic [`BITS_Y_POS-1:0]     cur_pos_y,
    output logic [`BITS_ROT-1:0]       cur_rot,
    output logic [`BITS_PER_BLOCK-1:0] cur_piece,
    output logic                       lock_req,
    output logic                       next_req,
    output logic                       game_clk_rst,
    output logic                       game_over,
    output logic [`BITS_SCORE-1:0]     piece_count
);

    typedef enum logic [2:0] {
        ST_SPAWN,
        ST_SPAWN_CHECK,
        ST_FALL,
        ST_LOCK_WAIT,
        ST_OVER
    } state_t;

    state_t state;

    logic play;
    logic move_evt;
    logic drop;

    assign play     = (mode == `MODE_PLAY);
    assign drop     = game_clk;
    assign move_evt = game_clk | btn_left_en | btn_right_en | btn_rotate_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_SPAWN;
            cur_pos_x    <= SPAWN_X;
            cur_pos_y    <= SPAWN_Y;
            cur_rot      <= SPAWN_ROT;
            cur_piece    <= `EMPTY_BLOCK;
            lock_req     <= 1'b0;
            next_req     <= 1'b0;
            game_clk_rst <= 1'b0;
            game_over    <= 1'b0;
            piece_count  <= '0;
        end else begin
            // Pulse outputs default low; each is raised from a state that lasts one cycle.
            next_req     <= 1'b0;
            game_clk_rst <= 1'b0;
            case (state)
                ST_SPAWN: begin
                    if (play) begin
                        cur_pos_x <= SPAWN_X;
                        cur_pos_y <= SPAWN_Y;
                        cur_rot   <= SPAWN_ROT;
                        cur_piece <= next_piece;
                        next_req  <= 1'b1;
                        state     <= ST_SPAWN_CHECK;
                    end
                end
                ST_SPAWN_CHECK: begin
                    // While an event is active the test stage shows a moved candidate,
                    // so the spawn position is only judged on a quiet cycle.
                    if (play && !move_evt) begin
                        if (test_intersects) begin
                            game_over <= 1'b1;
                            state     <= ST_OVER;
                        end else begin
                            game_clk_rst <= 1'b1;
                            state        <= ST_FALL;
                        end
                    end
                end
                ST_FALL: begin
                    if (play && move_evt) begin
                        if (!test_intersects) begin
                            cur_pos_x <= test_pos_x;
                            cur_pos_y <= test_pos_y;
                            cur_rot   <= test_rot;
                        end else if (drop) begin
                            lock_req <= 1'b1;
                            state    <= ST_LOCK_WAIT;
                        end
                    end
                end
                ST_LOCK_WAIT: begin
                    // Handshake completes regardless of mode so the board writer never stalls.
                    if (lock_ack) begin
                        lock_req <= 1'b0;
                        if (piece_count != {`BITS_SCORE{1'b1}})
                            piece_count <= piece_count + 1'b1;
                        state <= ST_SPAWN;
                    end
                end
                ST_OVER: begin
                    game_over <= 1'b1;
                end
                default: state <= ST_SPAWN;
            endcase
        end
    end

endmodule

// File: tb/tb_piece_state_ctrl.sv
module tb_piece_state_ctrl;

    localparam logic [1:0] PLAY  = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam int SAT = 16383;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       game_clk, btn_left_en, btn_right_en, btn_rotate_en;
    logic [3:0] test_pos_x;
    logic [4:0] test_pos_y;
    logic [1:0] test_rot;
    logic       test_intersects;
    logic [2:0] next_piece;
    logic       lock_ack;
    logic [3:0] cur_pos_x;
    logic [4:0] cur_pos_y;
    logic [1:0] cur_rot;
    logic [2:0] cur_piece;
    logic       lock_req, next_req, game_clk_rst, game_over;
    logic [13:0] piece_count;

    int tests_run = 0;
    int fails     = 0;

    always #5 clk = ~clk;

    piece_state_ctrl dut (
        .clk(clk), .rst(rst), .mode(mode), .game_clk(game_clk),
        .btn_left_en(btn_left_en), .btn_right_en(btn_right_en), .btn_rotate_en(btn_rotate_en),
        .test_pos_x(test_pos_x), .test_pos_y(test_pos_y), .test_rot(test_rot),
        .test_intersects(test_intersects), .next_piece(next_piece), .lock_ack(lock_ack),
        .cur_pos_x(cur_pos_x), .cur_pos_y(cur_pos_y), .cur_rot(cur_rot), .cur_piece(cur_piece),
        .lock_req(lock_req), .next_req(next_req), .game_clk_rst(game_clk_rst),
        .game_over(game_over), .piece_count(piece_count)
    );

    // Behavioural reference: which step of a piece's life we are in, plus what the
    // outside world should see. Updated from the rules before each clock edge.
    typedef enum {NEED_PIECE, JUDGE_SPAWN, FALLING, WAIT_BOARD, DEAD} life_t;
    life_t m_life;
    int m_x, m_y, m_rot, m_piece, m_count;
    bit m_lock, m_next, m_gcr, m_over;

    task automatic model_tick();
        bit play_now, any_evt;
        play_now = (mode == PLAY);
        any_evt  = game_clk || btn_left_en || btn_right_en || btn_rotate_en;
        m_next = 0;
        m_gcr  = 0;
        if (rst) begin
            m_life = NEED_PIECE; m_x = 4; m_y = 0; m_rot = 0; m_piece = 0;
            m_lock = 0; m_over = 0; m_count = 0;
        end else if (m_life == NEED_PIECE) begin
            if (play_now) begin
                m_x = 4; m_y = 0; m_rot = 0; m_piece = next_piece;
                m_next = 1; m_life = JUDGE_SPAWN;
            end
        end else if (m_life == JUDGE_SPAWN) begin
            if (play_now && !any_evt) begin
                if (test_intersects) begin m_over = 1; m_life = DEAD; end
                else begin m_gcr = 1; m_life = FALLING; end
            end
        end else if (m_life == FALLING) begin
            if (play_now && any_evt && !test_intersects) begin
                m_x = test_pos_x; m_y = test_pos_y; m_rot = test_rot;
            end else if (play_now && game_clk && test_intersects) begin
                m_lock = 1; m_life = WAIT_BOARD;
            end
        end else if (m_life == WAIT_BOARD) begin
            if (lock_ack) begin
                m_lock = 0;
                m_count = (m_count + 1 > SAT) ? SAT : m_count + 1;
                m_life = NEED_PIECE;
            end
        end
    endtask

    // Advance model and DUT by one clock; outputs are stable when this returns.
    task automatic cycle();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input logic inter);
        game_clk = 0; btn_left_en = 0; btn_right_en = 0; btn_rotate_en = 0;
        lock_ack = 0; test_intersects = inter;
    endtask

    // Spawn a piece, fall, and reach the board-write wait (stimulus only).
    task automatic drive_to_lock_wait();
        quiet(0); cycle(); cycle();
        game_clk = 1; test_intersects = 1; cycle();
        quiet(0);
    endtask

    task automatic test_reset();
        rst = 1; mode = PLAY; quiet(0); next_piece = 3'b011;
        test_pos_x = 0; test_pos_y = 0; test_rot = 0;
        cycle(); cycle();
        tests_run++;
        if ({cur_pos_x, cur_pos_y, cur_rot, cur_piece} !== {4'd4, 5'd0, 2'd0, 3'd0}) begin
            fails++; $display("FAIL reset_pos got %h %h %h %h want 4 0 0 0", cur_pos_x, cur_pos_y, cur_rot, cur_piece);
        end
        tests_run++;
        if ({lock_req, next_req, game_clk_rst, game_over, piece_count} !== 18'd0) begin
            fails++; $display("FAIL reset_flags got %b%b%b%b cnt=%0d want 0000 cnt=0", lock_req, next_req, game_clk_rst, game_over, piece_count);
        end
    endtask

    task automatic test_spawn();
        rst = 0; cycle();
        tests_run++;
        if ({next_req, cur_piece, cur_pos_x, cur_pos_y, cur_rot} !== {1'b1, 3'b011, 4'd4, 5'd0, 2'd0}) begin
            fails++; $display("FAIL spawn_load got nr=%b p=%b x=%0d y=%0d r=%0d want nr=1 p=011 4,0,0", next_req, cur_piece, cur_pos_x, cur_pos_y, cur_rot);
        end
        cycle();
        tests_run++;
        if ({next_req, game_clk_rst} !== 2'b01) begin
            fails++; $display("FAIL spawn_check got nr=%b gcr=%b want nr=0 gcr=1", next_req, game_clk_rst);
        end
        cycle();
        tests_run++;
        if (game_clk_rst !== 1'b0) begin
            fails++; $display("FAIL gcr_pulse got %b want 0", game_clk_rst);
        end
    endtask

    task automatic test_fall_move();
        game_clk = 1; test_pos_x = 4; test_pos_y = 5; test_rot = 0; cycle();
        test_pos_y = 6; cycle();
        tests_run++;
        if (cur_pos_y !== 5'd6) begin
            fails++; $display("FAIL drop_commit got y=%0d want 6", cur_pos_y);
        end
        game_clk = 0; btn_left_en = 1; test_pos_x = 3; test_intersects = 1; cycle();
        tests_run++;
        if ({cur_pos_x, lock_req} !== {4'd4, 1'b0}) begin
            fails++; $display("FAIL left_blocked got x=%0d lr=%b want x=4 lr=0", cur_pos_x, lock_req);
        end
        test_pos_x = 4'd15; test_intersects = 0; cycle();
        tests_run++;
        if (cur_pos_x !== 4'd15) begin
            fails++; $display("FAIL x_wrap got x=%0d want 15", cur_pos_x);
        end
        btn_left_en = 0; btn_rotate_en = 1; test_pos_x = 15; test_pos_y = 20; test_rot = 3; cycle();
        tests_run++;
        if ({cur_pos_y, cur_rot} !== {5'd20, 2'd3}) begin
            fails++; $display("FAIL rotate_commit got y=%0d r=%0d want 20 3", cur_pos_y, cur_rot);
        end
        quiet(0);
    endtask

    task automatic test_lock();
        game_clk = 1; test_intersects = 1; test_pos_y = 21; cycle();
        quiet(0);
        tests_run++;
        if ({lock_req, cur_pos_y} !== {1'b1, 5'd20}) begin
            fails++; $display("FAIL lock_enter got lr=%b y=%0d want lr=1 y=20", lock_req, cur_pos_y);
        end
        btn_right_en = 1; game_clk = 1; cycle(); cycle(); cycle();
        tests_run++;
        if ({lock_req, piece_count} !== {1'b1, 14'd0}) begin
            fails++; $display("FAIL lock_hold got lr=%b cnt=%0d want lr=1 cnt=0", lock_req, piece_count);
        end
        quiet(0); lock_ack = 1; next_piece = 3'b101; cycle();
        lock_ack = 0;
        tests_run++;
        if ({lock_req, piece_count, next_req} !== {1'b0, 14'd1, 1'b0}) begin
            fails++; $display("FAIL lock_done got lr=%b cnt=%0d nr=%b want 0 1 0", lock_req, piece_count, next_req);
        end
        cycle();
        tests_run++;
        if ({next_req, cur_piece} !== {1'b1, 3'b101}) begin
            fails++; $display("FAIL respawn got nr=%b p=%b want 1 101", next_req, cur_piece);
        end
    endtask

    task automatic test_freeze();
        quiet(0); cycle();
        mode = PAUSE; game_clk = 1; test_pos_x = 7; test_pos_y = 9; test_rot = 2; cycle(); cycle();
        tests_run++;
        if ({cur_pos_x, cur_pos_y, cur_rot} !== {4'd4, 5'd0, 2'd0}) begin
            fails++; $display("FAIL freeze_fall got %0d,%0d,%0d want 4,0,0", cur_pos_x, cur_pos_y, cur_rot);
        end
        mode = PLAY; test_intersects = 1; cycle();
        mode = PAUSE; quiet(0); lock_ack = 1; cycle();
        lock_ack = 0;
        tests_run++;
        if ({lock_req, piece_count} !== {1'b0, 14'd2}) begin
            fails++; $display("FAIL freeze_lock got lr=%b cnt=%0d want 0 2", lock_req, piece_count);
        end
        cycle(); cycle();
        tests_run++;
        if (next_req !== 1'b0) begin
            fails++; $display("FAIL freeze_spawn got nr=%b want 0", next_req);
        end
        mode = PLAY; cycle();
        tests_run++;
        if (next_req !== 1'b1) begin
            fails++; $display("FAIL unfreeze_spawn got nr=%b want 1", next_req);
        end
    endtask

    task automatic test_spawn_over();
        quiet(1); btn_rotate_en = 1; cycle(); cycle();
        tests_run++;
        if ({game_over, game_clk_rst} !== 2'b00) begin
            fails++; $display("FAIL spawn_wait got go=%b gcr=%b want 0 0", game_over, game_clk_rst);
        end
        quiet(1); cycle();
        tests_run++;
        if (game_over !== 1'b1) begin
            fails++; $display("FAIL game_over got %b want 1", game_over);
        end
        game_clk = 1; lock_ack = 1; test_intersects = 0;
        for (int i = 0; i < 5; i++) cycle();
        tests_run++;
        if ({game_over, next_req, lock_req, game_clk_rst, piece_count} !== {4'b1000, 14'd2}) begin
            fails++; $display("FAIL over_sticky got go=%b nr=%b lr=%b gcr=%b cnt=%0d want 1000 cnt=2", game_over, next_req, lock_req, game_clk_rst, piece_count);
        end
        quiet(0);
    endtask

    task automatic test_rst_mid_lock();
        rst = 1; cycle(); rst = 0;
        drive_to_lock_wait();
        lock_ack = 1; cycle(); lock_ack = 0;
        drive_to_lock_wait();
        game_clk = 1; test_pos_x = 9; test_intersects = 0; cycle(); quiet(0);
        tests_run++;
        if ({lock_req, piece_count} !== {1'b1, 14'd1}) begin
            fails++; $display("FAIL pre_rst got lr=%b cnt=%0d want 1 1", lock_req, piece_count);
        end
        rst = 1; cycle(); rst = 0;
        tests_run++;
        if ({lock_req, piece_count, cur_pos_x, cur_pos_y, cur_rot, cur_piece} !== {1'b0, 14'd0, 4'd4, 5'd0, 2'd0, 3'd0}) begin
            fails++; $display("FAIL rst_mid_lock got lr=%b cnt=%0d %0d,%0d,%0d p=%0d want 0 0 4,0,0 p=0", lock_req, piece_count, cur_pos_x, cur_pos_y, cur_rot, cur_piece);
        end
    endtask

    task automatic test_random();
        bit prev_nr, prev_gcr;
        prev_nr = next_req; prev_gcr = game_clk_rst;
        for (int i = 0; i < 3000; i++) begin
            rst             = ($urandom_range(0, 299) == 0);
            mode            = ($urandom_range(0, 9) == 0) ? PAUSE : PLAY;
            game_clk        = ($urandom_range(0, 4) == 0);
            btn_left_en     = ($urandom_range(0, 5) == 0);
            btn_right_en    = ($urandom_range(0, 5) == 0);
            btn_rotate_en   = ($urandom_range(0, 5) == 0);
            test_pos_x      = 4'($urandom);
            test_pos_y      = 5'($urandom);
            test_rot        = 2'($urandom);
            test_intersects = ($urandom_range(0, 9) < 3);
            next_piece      = 3'($urandom);
            lock_ack        = ($urandom_range(0, 2) == 0);
            cycle();
            tests_run++;
            if ({cur_pos_x, cur_pos_y, cur_rot, cur_piece, lock_req, next_req, game_clk_rst, game_over, piece_count} !==
                {4'(m_x), 5'(m_y), 2'(m_rot), 3'(m_piece), m_lock, m_next, m_gcr, m_over, 14'(m_count)}) begin
                fails++;
                $display("FAIL random[%0d] got x=%0d y=%0d r=%0d p=%0d lr=%b nr=%b gcr=%b go=%b cnt=%0d want x=%0d y=%0d r=%0d p=%0d lr=%b nr=%b gcr=%b go=%b cnt=%0d",
                         i, cur_pos_x, cur_pos_y, cur_rot, cur_piece, lock_req, next_req, game_clk_rst, game_over, piece_count,
                         m_x, m_y, m_rot, m_piece, m_lock, m_next, m_gcr, m_over, m_count);
            end
            tests_run++;
            if ((prev_nr && next_req) || (prev_gcr && game_clk_rst)) begin
                fails++; $display("FAIL pulse_repeat[%0d] got nr=%b%b gcr=%b%b want no consecutive highs", i, prev_nr, next_req, prev_gcr, game_clk_rst);
            end
            prev_nr = next_req; prev_gcr = game_clk_rst;
        end
        rst = 0; mode = PLAY; quiet(0);
    endtask

    task automatic test_saturation();
        rst = 1; cycle(); rst = 0;
        for (int i = 0; i < SAT; i++) begin
            drive_to_lock_wait();
            lock_ack = 1; cycle(); lock_ack = 0;
        end
        tests_run++;
        if (piece_count !== 14'd16383) begin
            fails++; $display("FAIL count_max got %0d want 16383", piece_count);
        end
        drive_to_lock_wait();
        lock_ack = 1; cycle(); lock_ack = 0;
        tests_run++;
        if ({piece_count, lock_req} !== {14'd16383, 1'b0} || m_count != SAT) begin
            fails++; $display("FAIL count_sat got %0d lr=%b want 16383 lr=0 (model %0d)", piece_count, lock_req, m_count);
        end
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_fall_move();
        test_lock();
        test_freeze();
        test_spawn_over();
        test_rst_mid_lock();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
